// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state encoding for the transmit and receive paths.
`timescale 1ns/1ps
package uart_pkg;

    localparam int unsigned UART_DIV_9600  = 5208;
    localparam int unsigned UART_DATA_BITS = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..DIV-1 and pulses bit_tick on the last count.
`timescale 1ns/1ps
module uart_baud_gen #(
    parameter int unsigned DIV = 5208
) (
    input  logic CLK50MHz,
    input  logic RESET,
    input  logic clear,
    output logic bit_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign bit_tick = (cnt_q == CW'(DIV - 1));

    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= '0;
        end else if (clear || bit_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to include the parity bit (8E1/8E2); otherwise 8N1/8N2.
`timescale 1ns/1ps
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DIV       = CLK_HZ / BAUD,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       CLK50MHz,
    input  logic       RESET,
    input  logic [7:0] DATA_IN,
    input  logic       SEND,
    output logic       READY,
    output logic       TX,
    output logic       BUSY
);

    logic [2:0] state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic       stop_q, stop_d;
    logic       tx_q, tx_d;
    logic       bit_tick;
    logic       last_stop;
`ifdef UART_TX_PARITY_EN
    logic       parity_q, parity_d;
`endif

    // Counter held at zero while idle so the start bit lasts exactly DIV clocks.
    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud (
        .CLK50MHz (CLK50MHz),
        .RESET    (RESET),
        .clear    (state_q == S_IDLE),
        .bit_tick (bit_tick)
    );

    assign last_stop = (STOP_BITS == 1) || stop_q;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        stop_d   = stop_q;
        tx_d     = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (SEND) begin
                    state_d  = S_START;
                    shift_d  = DATA_IN;
                    idx_d    = '0;
                    stop_d   = 1'b0;
                    tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^DATA_IN;
`endif
                end
            end
            S_START: begin
                if (bit_tick) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    if (idx_q == 3'(UART_DATA_BITS - 1)) begin
                        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_tick) begin
                    if (last_stop) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        stop_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign READY = (state_q == S_IDLE);
    assign BUSY  = !READY;
    assign TX    = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised scoreboard bench for uart_tx with a reduced DIV; a line monitor decodes frames.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int unsigned DIV       = 16;
    localparam int unsigned STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned NBITS = 10 + PAR + STOP_BITS - 1;

    logic       CLK50MHz = 1'b0;
    logic       RESET    = 1'b0;
    logic [7:0] DATA_IN  = 8'h00;
    logic       SEND     = 1'b0;
    logic       READY, TX, BUSY;

    int         n_checks = 0;
    int         n_pass   = 0;
    longint     cyc      = 0;
    logic [7:0] exp_q[$];
    int         frames_seen = 0;
    longint     last_end = -100;
    longint     last_gap = 0;

    uart_tx #(
        .DIV       (DIV),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .CLK50MHz (CLK50MHz),
        .RESET    (RESET),
        .DATA_IN  (DATA_IN),
        .SEND     (SEND),
        .READY    (READY),
        .TX       (TX),
        .BUSY     (BUSY)
    );

    always #5 CLK50MHz = ~CLK50MHz;
    always @(posedge CLK50MHz) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, got, exp);
    endtask

    // Monitor: entered on the negedge where the start bit first appears.
    task automatic run_frame();
        logic [7:0] exp_b;
        logic [7:0] got_b;
        logic       bits[$];
        bit         aborted;
        int         bad;
        longint     t0;
        aborted  = 0;
        got_b    = 8'h00;
        t0       = cyc;
        last_gap = cyc - last_end;
        if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
            exp_b = 8'h00;
        end else begin
            exp_b = exp_q.pop_front();
        end
        check("busy_at_start", BUSY, 1);
        check("ready_at_start", READY, 0);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(((exp_b >> i) & 8'h01) != 0);
        if (PAR == 1) bits.push_back(($countones(exp_b) % 2) == 1);
        for (int i = 0; i < int'(STOP_BITS); i++) bits.push_back(1'b1);
        for (int b = 0; b < int'(NBITS); b++) begin
            bad = 0;
            for (int c = 0; c < int'(DIV); c++) begin
                if (!(b == 0 && c == 0)) @(negedge CLK50MHz);
                if (!RESET) begin
                    aborted = 1;
                    break;
                end
                if (TX !== bits[b]) bad++;
                if (c == int'(DIV / 2) && b >= 1 && b <= 8) got_b[b-1] = TX;
            end
            if (aborted) break;
            check($sformatf("bit%0d_level_of_%02h", b, exp_b), bad, 0);
        end
        if (aborted) return;
        frames_seen++;
        check("decoded_byte", got_b, exp_b);
        @(negedge CLK50MHz);
        check("ready_after_frame", READY, 1);
        check("busy_after_frame", BUSY, 0);
        check("frame_len", cyc - t0, NBITS * DIV);
        last_end = cyc;
    endtask

    initial begin : monitor
        logic prev_tx;
        prev_tx = 1'b1;
        forever begin
            @(negedge CLK50MHz);
            if (RESET && prev_tx && !TX) run_frame();
            prev_tx = TX;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge CLK50MHz);
        while (!READY && n < 5000) begin
            @(negedge CLK50MHz);
            n++;
        end
        if (n >= 5000) check("ready_timeout", 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready();
        DATA_IN = b;
        SEND    = 1'b1;
        exp_q.push_back(b);
        @(negedge CLK50MHz);
        SEND    = 1'b0;
        DATA_IN = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge CLK50MHz);
        while ((exp_q.size() != 0 || !READY) && n < 20000) begin
            @(negedge CLK50MHz);
            n++;
        end
        if (n >= 20000) check("idle_timeout", 0, 1);
        repeat (2 * DIV) @(negedge CLK50MHz);
    endtask

    initial begin : stimulus
        int lows;
        int f0;
        int n;
        logic [7:0] rb;
        repeat (3) @(negedge CLK50MHz);
        check("rst_tx", TX, 1);
        check("rst_ready", READY, 1);
        check("rst_busy", BUSY, 0);
        RESET = 1'b1;
        lows = 0;
        repeat (200) begin
            @(negedge CLK50MHz);
            if (!TX || BUSY || !READY) lows++;
        end
        check("idle_quiet", lows, 0);

        send_byte(8'h55);
        wait_idle();
        send_byte(8'h07);
        wait_idle();
        send_byte(8'h00);
        wait_idle();

        // SEND held high across two frames.
        wait_ready();
        DATA_IN = 8'hA5;
        SEND    = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge CLK50MHz);
        DATA_IN = 8'h3C;
        exp_q.push_back(8'h3C);
        n = 0;
        do begin
            @(negedge CLK50MHz);
            n++;
        end while (!READY && n < 5000);
        @(negedge CLK50MHz);
        SEND = 1'b0;
        wait_idle();
        check("b2b_gap", last_gap, 1);

        // SEND while busy and DATA_IN churn must not disturb the frame.
        f0 = frames_seen;
        send_byte(8'h12);
        for (int i = 0; i < int'(4 * DIV); i++) begin
            DATA_IN = (i == 2 * int'(DIV)) ? 8'hFF : 8'($urandom);
            SEND    = (i == 2 * int'(DIV));
            @(negedge CLK50MHz);
        end
        SEND = 1'b0;
        wait_idle();
        check("ignored_send_frames", frames_seen - f0, 1);

        // Reset in the middle of D3 of 0x81 (D3 = 0).
        send_byte(8'h81);
        repeat (4 * DIV + DIV / 2 - 1) @(negedge CLK50MHz);
        check("pre_reset_tx_low", TX, 0);
        #2 RESET = 1'b0;
        #1;
        check("async_rst_tx", TX, 1);
        check("async_rst_ready", READY, 1);
        check("async_rst_busy", BUSY, 0);
        repeat (3) @(negedge CLK50MHz);
        RESET = 1'b1;
        send_byte(8'h42);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            send_byte(rb);
            repeat ($urandom_range(0, 20)) @(negedge CLK50MHz);
        end
        wait_idle();

        check("frames_total", frames_seen, 13);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
